// File: rtl/sys_bus_pkg.sv
// Shared types and constants for the processor bus: FSM states, legacy source
// indices and default geometry.
package sys_bus_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam int SRC_R    = 0;
    localparam int SRC_AR   = 1;
    localparam int SRC_DR   = 2;
    localparam int SRC_AC   = 3;
    localparam int SRC_PC   = 4;
    localparam int SRC_IR   = 5;
    localparam int SRC_DRAM = 6;
    localparam int SRC_IRAM = 7;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_N_REG   = 6;
    localparam int DEF_N_MEM   = 2;
    localparam int DEF_MEM_LAT = 2;

    // Index width for n alternatives, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sys_bus_onehot_dec.sv
// One-hot to binary decoder with zero / multi-hot flags; purely combinational
// and shared with the control unit's microcode checks.
module onehot_dec
    import sys_bus_pkg::*;
#(
    parameter int W     = DEF_N_REG + DEF_N_MEM,
    parameter int IDX_W = idx_w(W)
) (
    input  logic [W-1:0]     src_sel,
    output logic [IDX_W-1:0] index,
    output logic             is_zero,
    output logic             is_multi
);

    // index is only meaningful when exactly one bit is set.
    always_comb begin
        index = '0;
        for (int i = 0; i < W; i++) begin
            if (src_sel[i]) index = index | IDX_W'(i);
        end
    end

    assign is_zero  = (src_sel == '0);
    assign is_multi = |(src_sel & (src_sel - W'(1)));

endmodule

// File: rtl/sys_bus.sv
// Registered shared bus: one-cycle register reads, fixed-latency memory reads,
// rejection of malformed or overlapping requests.
module sys_bus
    import sys_bus_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int N_REG   = DEF_N_REG,
    parameter int N_MEM   = DEF_N_MEM,
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sel_valid,
    input  logic [N_REG+N_MEM-1:0]    src_sel,
    input  logic [N_REG*DATA_W-1:0]   reg_data,
    input  logic [N_MEM*DATA_W-1:0]   mem_data,
    input  logic [DATA_W-1:0]         ar_in,
    output logic [N_MEM-1:0]          mem_rd_req,
    output logic [DATA_W-1:0]         addr,
    output logic [DATA_W-1:0]         bus_data,
    output logic                      bus_valid,
    output logic                      busy,
    output logic                      sel_err
);

    localparam int SEL_W  = N_REG + N_MEM;
    localparam int IDX_W  = idx_w(SEL_W);
    localparam int MIDX_W = idx_w(N_MEM);
    localparam int CNT_W  = $clog2(MEM_LAT) + 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [MIDX_W-1:0]   mem_idx_q, mem_idx_d;
    logic [DATA_W-1:0]   bus_data_q, bus_data_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [N_MEM-1:0]    mem_rd_req_q, mem_rd_req_d;
    logic                bus_valid_q, bus_valid_d;
    logic                busy_q, busy_d;
    logic                sel_err_q, sel_err_d;

    logic [IDX_W-1:0]    sel_idx;
    logic                sel_zero, sel_multi;
    logic [DATA_W-1:0]   reg_word, mem_word;

    onehot_dec #(.W(SEL_W), .IDX_W(IDX_W)) u_dec (
        .src_sel  (src_sel),
        .index    (sel_idx),
        .is_zero  (sel_zero),
        .is_multi (sel_multi)
    );

    // Source muxes; the memory side uses the index captured at acceptance.
    always_comb begin
        reg_word = '0;
        for (int i = 0; i < N_REG; i++) begin
            if (sel_idx == IDX_W'(i)) reg_word = reg_data[i*DATA_W +: DATA_W];
        end
        mem_word = '0;
        for (int j = 0; j < N_MEM; j++) begin
            if (mem_idx_q == MIDX_W'(j)) mem_word = mem_data[j*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_idx_d    = mem_idx_q;
        bus_data_d   = bus_data_q;
        addr_d       = addr_q;
        mem_rd_req_d = '0;
        bus_valid_d  = 1'b0;
        sel_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    if (sel_zero) begin
                        bus_data_d  = '0;
                        bus_valid_d = 1'b1;
                    end else if (sel_multi) begin
                        sel_err_d = 1'b1;
                    end else if (sel_idx < IDX_W'(N_REG)) begin
                        bus_data_d  = reg_word;
                        bus_valid_d = 1'b1;
                    end else begin
                        addr_d  = ar_in;
                        cnt_d   = CNT_W'(MEM_LAT - 1);
                        state_d = MEM_WAIT;
                        for (int j = 0; j < N_MEM; j++) begin
                            if (sel_idx == IDX_W'(N_REG + j)) begin
                                mem_rd_req_d[j] = 1'b1;
                                mem_idx_d       = MIDX_W'(j);
                            end
                        end
                    end
                end
            end
            MEM_WAIT: begin
                // Requests arriving mid-read are dropped, never queued.
                sel_err_d = sel_valid;
                if (cnt_q == '0) begin
                    bus_data_d  = mem_word;
                    bus_valid_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase

        busy_d = (state_d == MEM_WAIT);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mem_idx_q    <= '0;
            bus_data_q   <= '0;
            addr_q       <= '0;
            mem_rd_req_q <= '0;
            bus_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            sel_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_idx_q    <= mem_idx_d;
            bus_data_q   <= bus_data_d;
            addr_q       <= addr_d;
            mem_rd_req_q <= mem_rd_req_d;
            bus_valid_q  <= bus_valid_d;
            busy_q       <= busy_d;
            sel_err_q    <= sel_err_d;
        end
    end

    assign mem_rd_req = mem_rd_req_q;
    assign addr       = addr_q;
    assign bus_data   = bus_data_q;
    assign bus_valid  = bus_valid_q;
    assign busy       = busy_q;
    assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_sys_bus.sv
// Scoreboard bench for sys_bus: the driver predicts timed output events from
// the bus rules, a negedge monitor pops and compares them against the DUT.
module tb_sys_bus;
    import sys_bus_pkg::*;

    localparam int DATA_W  = 16;
    localparam int N_REG   = 6;
    localparam int N_MEM   = 2;
    localparam int MEM_LAT = 2;
    localparam int SEL_W   = N_REG + N_MEM;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    sel_valid = 1'b0;
    logic [SEL_W-1:0]        src_sel = '0;
    logic [N_REG*DATA_W-1:0] reg_data = '0;
    logic [N_MEM*DATA_W-1:0] mem_data = '0;
    logic [DATA_W-1:0]       ar_in = '0;
    logic [N_MEM-1:0]        mem_rd_req;
    logic [DATA_W-1:0]       addr;
    logic [DATA_W-1:0]       bus_data;
    logic                    bus_valid;
    logic                    busy;
    logic                    sel_err;

    sys_bus #(.DATA_W(DATA_W), .N_REG(N_REG), .N_MEM(N_MEM), .MEM_LAT(MEM_LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel_valid  (sel_valid),
        .src_sel    (src_sel),
        .reg_data   (reg_data),
        .mem_data   (mem_data),
        .ar_in      (ar_in),
        .mem_rd_req (mem_rd_req),
        .addr       (addr),
        .bus_data   (bus_data),
        .bus_valid  (bus_valid),
        .busy       (busy),
        .sel_err    (sel_err)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far; outputs at a negedge belong to edge cyc.
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct { int cyc; logic [DATA_W-1:0] data; } val_ev_t;
    typedef struct { int cyc; int j; logic [DATA_W-1:0] addr; } req_ev_t;

    val_ev_t exp_val_q[$];
    req_ev_t exp_req_q[$];
    int      exp_err_q[$];

    int checks   = 0;
    int failures = 0;
    int wait_end = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Memory contents change every cycle so the capture edge is observable.
    function automatic logic [DATA_W-1:0] mem_word(input int c, input int j);
        return DATA_W'((c * 32'h3b1d) ^ (j * 32'h5a5a) ^ 32'hc3a5);
    endfunction

    // Reference rules: what a request sampled at edge k must produce, and when.
    task automatic model_request(input int k, input logic [SEL_W-1:0] sel,
                                 input logic [N_REG*DATA_W-1:0] rd,
                                 input logic [DATA_W-1:0] ar);
        int      ones;
        int      idx;
        val_ev_t v;
        req_ev_t r;
        ones = $countones(sel);
        idx  = 0;
        for (int i = 0; i < SEL_W; i++) if (sel[i]) idx = i;
        if (k <= wait_end || ones > 1) begin
            exp_err_q.push_back(k);
        end else if (ones == 0) begin
            v.cyc = k; v.data = '0;
            exp_val_q.push_back(v);
        end else if (idx < N_REG) begin
            v.cyc = k; v.data = rd[idx*DATA_W +: DATA_W];
            exp_val_q.push_back(v);
        end else begin
            r.cyc = k; r.j = idx - N_REG; r.addr = ar;
            exp_req_q.push_back(r);
            v.cyc = k + MEM_LAT; v.data = mem_word(k + MEM_LAT, idx - N_REG);
            exp_val_q.push_back(v);
            wait_end = k + MEM_LAT;
        end
    endtask

    task automatic step(input logic v, input logic [SEL_W-1:0] sel,
                        input logic [N_REG*DATA_W-1:0] rd, input logic [DATA_W-1:0] ar);
        int k;
        @(negedge clk);
        k = cyc + 1;
        sel_valid = v;
        src_sel   = sel;
        reg_data  = rd;
        ar_in     = ar;
        for (int j = 0; j < N_MEM; j++) mem_data[j*DATA_W +: DATA_W] = mem_word(k, j);
        if (v) model_request(k, sel, rd, ar);
    endtask

    function automatic logic [N_REG*DATA_W-1:0] rand_regs();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, SEL_W'($urandom), rand_regs(), DATA_W'($urandom));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " bus_data"},   bus_data,   '0);
        check({tag, " addr"},       addr,       '0);
        check({tag, " bus_valid"},  bus_valid,  '0);
        check({tag, " busy"},       busy,       '0);
        check({tag, " sel_err"},    sel_err,    '0);
        check({tag, " mem_rd_req"}, mem_rd_req, '0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n     = 1'b0;
        sel_valid = 1'b0;
        wait_end  = -1;
        #1;
        check_all_zero(tag);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: derives held values (addr, bus_data, busy window) from popped events.
    initial begin
        int               busy_until;
        logic [DATA_W-1:0] exp_addr, exp_bus;
        logic [N_MEM-1:0] exp_req;
        logic             exp_v, exp_e;
        req_ev_t          r;
        busy_until = -1;
        exp_addr   = '0;
        exp_bus    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_val_q.delete();
                exp_req_q.delete();
                exp_err_q.delete();
                busy_until = -1;
                exp_addr   = '0;
                exp_bus    = '0;
                continue;
            end
            exp_req = '0;
            if (exp_req_q.size() > 0 && exp_req_q[0].cyc == cyc) begin
                r          = exp_req_q.pop_front();
                exp_req    = N_MEM'(1) << r.j;
                exp_addr   = r.addr;
                busy_until = cyc + MEM_LAT - 1;
            end
            check("mem_rd_req", mem_rd_req, exp_req);
            check("addr", addr, exp_addr);
            check("busy", busy, cyc <= busy_until);
            exp_v = 1'b0;
            if (exp_val_q.size() > 0 && exp_val_q[0].cyc == cyc) begin
                exp_v   = 1'b1;
                exp_bus = exp_val_q.pop_front().data;
            end
            check("bus_valid", bus_valid, exp_v);
            check("bus_data", bus_data, exp_bus);
            exp_e = 1'b0;
            if (exp_err_q.size() > 0 && exp_err_q[0] == cyc) begin
                exp_e = 1'b1;
                void'(exp_err_q.pop_front());
            end
            check("sel_err", sel_err, exp_e);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N_REG*DATA_W-1:0] rd;
        logic [SEL_W-1:0]        sel;
        int                      kind, a, b;

        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Register AC read.
        rd = rand_regs();
        rd[SRC_AC*DATA_W +: DATA_W] = 16'hBEEF;
        step(1'b1, 8'b0000_1000, rd, 16'h7777);
        idle(1);

        // DRAM read with full latency, then multi-hot and zero-hot requests.
        step(1'b1, 8'b0100_0000, rand_regs(), 16'h0123);
        idle(MEM_LAT + 1);
        step(1'b1, 8'b0000_0011, rand_regs(), 16'h1111);
        idle(1);
        step(1'b1, 8'b0000_0000, rand_regs(), 16'h2222);
        idle(1);

        // IRAM read, PC dropped mid-wait, PC accepted in the bus_valid cycle.
        step(1'b1, 8'b1000_0000, rand_regs(), 16'h0456);
        step(1'b1, 8'b0001_0000, rand_regs(), 16'h3333);
        idle(MEM_LAT - 1);
        step(1'b1, 8'b0001_0000, rand_regs(), 16'h4444);
        idle(2);

        // Reset during MEM_WAIT aborts the read.
        step(1'b1, 8'b0100_0000, rand_regs(), 16'h0999);
        do_reset("midread");
        idle(MEM_LAT + 2);
        step(1'b1, 8'b0000_0100, rand_regs(), 16'h5555);
        step(1'b1, 8'b1000_0000, rand_regs(), 16'h0abc);
        idle(MEM_LAT + 1);

        // Randomised traffic, including back-to-back and overlapping requests.
        for (int n = 0; n < 600; n++) begin
            kind = $urandom_range(0, 9);
            a    = $urandom_range(0, SEL_W - 1);
            b    = (a + $urandom_range(1, SEL_W - 1)) % SEL_W;
            sel  = '0;
            if (kind == 0)      sel = '0;
            else if (kind <= 5) sel[$urandom_range(0, N_REG - 1)] = 1'b1;
            else if (kind <= 7) sel[N_REG + $urandom_range(0, N_MEM - 1)] = 1'b1;
            else begin
                sel[a] = 1'b1;
                sel[b] = 1'b1;
            end
            step($urandom_range(0, 9) < 7, sel, rand_regs(), DATA_W'($urandom));
        end

        idle(MEM_LAT + 4);
        check("drain", exp_val_q.size() + exp_req_q.size() + exp_err_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
